// File: rtl/l2_pri_bank_arb_pkg.sv
// Shared types for the private L2 bank arbiter: FSM state encoding and master index type.
package l2_pri_bank_arb_pkg;

   typedef enum logic {
      ARB  = 1'b0,
      INIT = 1'b1
   } arb_state_e;

   localparam int NB_MASTERS_MAX = 8;

   typedef logic [$clog2(NB_MASTERS_MAX)-1:0] master_idx_t;

   // Successor of idx in a ring of n masters.
   function automatic master_idx_t next_idx(input master_idx_t idx, input int n);
      if (int'(idx) + 1 >= n) begin
         return '0;
      end
      return master_idx_t'(idx + 1'b1);
   endfunction

endpackage

// File: rtl/l2_pri_bank_rr_pick.sv
// Rotate-priority picker: first asserted request at or above rr_ptr, wrapping around.
module l2_pri_bank_rr_pick
   import l2_pri_bank_arb_pkg::*;
#(
   parameter int NB_MASTERS = 2
) (
   input  logic [NB_MASTERS-1:0]               req,
   input  logic [$clog2(NB_MASTERS_MAX)-1:0]   rr_ptr,
   output logic [$clog2(NB_MASTERS_MAX)-1:0]   winner,
   output logic                                any_req
);

   logic [NB_MASTERS_MAX-1:0] req_pad;
   logic                      found;
   int                        cand;

   assign req_pad = NB_MASTERS_MAX'(req);
   assign any_req = |req;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      cand   = 0;
      for (int i = 0; i < NB_MASTERS; i++) begin
         cand = int'(rr_ptr) + i;
         if (cand >= NB_MASTERS) begin
            cand = cand - NB_MASTERS;
         end
         if (!found && req_pad[master_idx_t'(cand)]) begin
            found  = 1'b1;
            winner = master_idx_t'(cand);
         end
      end
   end

endmodule

// File: rtl/l2_pri_bank_arbiter.sv
// Round-robin arbiter sharing one private L2 bank among NB_MASTERS requesters, with response routing.
// Optional post-reset bank fill is compiled in with L2_PRI_BANK_ARB_INIT_EN.
module l2_pri_bank_arbiter
   import l2_pri_bank_arb_pkg::*;
#(
   parameter int          NB_MASTERS = 2,
   parameter int          MEM_WORDS  = 8192,
   parameter logic [31:0] BASE_ADDR  = 32'h1C00_0000,
   parameter logic [31:0] INIT_VALUE = 32'h0
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [NB_MASTERS-1:0]    m_req_i,
   input  logic [NB_MASTERS*32-1:0] m_add_i,
   input  logic [NB_MASTERS-1:0]    m_wen_i,
   input  logic [NB_MASTERS*4-1:0]  m_be_i,
   input  logic [NB_MASTERS*32-1:0] m_wdata_i,
   output logic [NB_MASTERS-1:0]    m_gnt_o,
   output logic [NB_MASTERS-1:0]    m_r_valid_o,
   output logic [31:0]              m_r_rdata_o,
   output logic                     s_req_o,
   output logic [31:0]              s_add_o,
   output logic                     s_wen_o,
   output logic [3:0]               s_be_o,
   output logic [31:0]              s_wdata_o,
   input  logic                     s_gnt_i,
   input  logic                     s_r_valid_i,
   input  logic [31:0]              s_r_rdata_i,
   input  logic                     init_req_i,
   output logic                     init_done_o
);

   master_idx_t rr_ptr_q;
   master_idx_t pick_idx;
   master_idx_t sel_idx;
   master_idx_t resp_id_q;
   master_idx_t lock_id_q;
   logic        any_req;
   logic        lock_q;
   logic        resp_valid_q;
   logic        in_init;
   logic        xfer_done;
   logic [31:0] init_add;

   l2_pri_bank_rr_pick #(
      .NB_MASTERS (NB_MASTERS)
   ) u_pick (
      .req     (m_req_i),
      .rr_ptr  (rr_ptr_q),
      .winner  (pick_idx),
      .any_req (any_req)
   );

   // A stalled winner stays locked so a late higher-priority request cannot steal the slave port.
   assign sel_idx   = lock_q ? lock_id_q : pick_idx;
   assign xfer_done = !in_init && any_req && s_gnt_i;

`ifdef L2_PRI_BANK_ARB_INIT_EN
   localparam int CNT_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

   arb_state_e       state_q;
   arb_state_e       state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ARB: begin
            if (init_req_i) begin
               state_d = INIT;
               cnt_d   = '0;
            end
         end
         INIT: begin
            if (s_gnt_i) begin
               if (cnt_q == CNT_W'(MEM_WORDS - 1)) begin
                  state_d = ARB;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
      endcase
   end

   assign in_init     = (state_q == INIT);
   assign init_add    = BASE_ADDR + (32'(cnt_q) << 2);
   assign init_done_o = (state_q == ARB);
`else
   logic unused_cfg;

   assign in_init     = 1'b0;
   assign init_add    = '0;
   assign init_done_o = 1'b1;
   assign unused_cfg  = ^{init_req_i, BASE_ADDR, 32'(MEM_WORDS)};
`endif

   // Pointer, response tag and stall lock; init writes never produce a tagged response.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_q     <= '0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= '0;
         lock_q       <= 1'b0;
         lock_id_q    <= '0;
      end else begin
         resp_valid_q <= xfer_done;
         if (xfer_done) begin
            rr_ptr_q  <= next_idx(sel_idx, NB_MASTERS);
            resp_id_q <= sel_idx;
         end
         lock_q    <= !in_init && any_req && !s_gnt_i;
         lock_id_q <= sel_idx;
      end
   end

   always_comb begin
      m_gnt_o     = '0;
      m_r_valid_o = '0;
      m_r_rdata_o = '0;
      s_req_o     = 1'b0;
      s_add_o     = '0;
      s_wen_o     = 1'b0;
      s_be_o      = '0;
      s_wdata_o   = '0;
      if (rst_ni) begin
         m_r_rdata_o = s_r_rdata_i;
         for (int i = 0; i < NB_MASTERS; i++) begin
            if (resp_id_q == master_idx_t'(i)) begin
               m_r_valid_o[i] = resp_valid_q && s_r_valid_i;
            end
         end
         if (in_init) begin
            s_req_o   = 1'b1;
            s_add_o   = init_add;
            s_wen_o   = 1'b0;
            s_be_o    = 4'hF;
            s_wdata_o = INIT_VALUE;
         end else begin
            s_req_o = any_req;
            for (int i = 0; i < NB_MASTERS; i++) begin
               if (sel_idx == master_idx_t'(i)) begin
                  s_add_o    = m_add_i[i*32 +: 32];
                  s_wen_o    = m_wen_i[i];
                  s_be_o     = m_be_i[i*4 +: 4];
                  s_wdata_o  = m_wdata_i[i*32 +: 32];
                  m_gnt_o[i] = any_req && s_gnt_i;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_l2_pri_bank_arbiter.sv
// Directed bench for l2_pri_bank_arbiter with two masters and a 16-word bank.
// Init-sequencer steps are compiled only when L2_PRI_BANK_ARB_INIT_EN is defined.
module tb_l2_pri_bank_arbiter;

   localparam int          NB   = 2;
   localparam logic [31:0] BASE = 32'h1C00_0000;
`ifdef L2_PRI_BANK_ARB_INIT_EN
   localparam logic [31:0] DONE_RST = 32'd0;
`else
   localparam logic [31:0] DONE_RST = 32'd1;
`endif

   logic              clk_i       = 1'b0;
   logic              rst_ni      = 1'b0;
   logic [NB-1:0]     m_req_i     = '0;
   logic [NB*32-1:0]  m_add_i     = '0;
   logic [NB-1:0]     m_wen_i     = '0;
   logic [NB*4-1:0]   m_be_i      = '1;
   logic [NB*32-1:0]  m_wdata_i   = '0;
   logic              init_req_i  = 1'b0;
   logic              gnt_low     = 1'b0;
   logic [31:0]       slave_rdata = '0;
   logic [NB-1:0]     m_gnt_o;
   logic [NB-1:0]     m_r_valid_o;
   logic [31:0]       m_r_rdata_o;
   logic              s_req_o;
   logic [31:0]       s_add_o;
   logic              s_wen_o;
   logic [3:0]        s_be_o;
   logic [31:0]       s_wdata_o;
   logic              s_gnt_i;
   logic              s_r_valid_i;
   logic [31:0]       s_r_rdata_i;
   logic              init_done_o;
   int                checks = 0;
   int                errors = 0;

   l2_pri_bank_arbiter #(
      .NB_MASTERS (NB),
      .MEM_WORDS  (16),
      .BASE_ADDR  (BASE),
      .INIT_VALUE (32'h0)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .m_req_i     (m_req_i),
      .m_add_i     (m_add_i),
      .m_wen_i     (m_wen_i),
      .m_be_i      (m_be_i),
      .m_wdata_i   (m_wdata_i),
      .m_gnt_o     (m_gnt_o),
      .m_r_valid_o (m_r_valid_o),
      .m_r_rdata_o (m_r_rdata_o),
      .s_req_o     (s_req_o),
      .s_add_o     (s_add_o),
      .s_wen_o     (s_wen_o),
      .s_be_o      (s_be_o),
      .s_wdata_o   (s_wdata_o),
      .s_gnt_i     (s_gnt_i),
      .s_r_valid_i (s_r_valid_i),
      .s_r_rdata_i (s_r_rdata_i),
      .init_req_i  (init_req_i),
      .init_done_o (init_done_o)
   );

   always #5 clk_i = ~clk_i;

   // Slave model: grants whenever asked unless stalled, answers every access one cycle later.
   assign s_gnt_i = s_req_o && !gnt_low;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s_r_valid_i <= 1'b0;
         s_r_rdata_i <= '0;
      end else begin
         s_r_valid_i <= s_req_o && s_gnt_i;
         s_r_rdata_i <= slave_rdata;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] req, input logic [1:0] wen, input logic [31:0] add0,
                                input logic [31:0] add1, input logic [31:0] wdata1, input logic init_req);
      @(posedge clk_i);
      #1;
      m_req_i    = req;
      m_wen_i    = wen;
      m_add_i    = {add1, add0};
      m_wdata_i  = {wdata1, 32'h0};
      init_req_i = init_req;
      #2;
   endtask

   task automatic nextCycle();
      @(posedge clk_i);
      #3;
   endtask

`ifdef L2_PRI_BANK_ARB_INIT_EN
   task automatic runInitSweep(input string tag);
      for (int k = 0; k < 16; k++) begin
         checkOutput({tag, " init add"}, s_add_o, BASE + 32'(k) * 4);
         checkOutput({tag, " init wen"}, 32'(s_wen_o), 32'd0);
         checkOutput({tag, " init gnt"}, 32'(m_gnt_o), 32'd0);
         checkOutput({tag, " init done low"}, 32'(init_done_o), 32'd0);
         if (k > 0) begin
            checkOutput({tag, " init rvalid"}, 32'(m_r_valid_o), 32'd0);
         end
         nextCycle();
      end
      checkOutput({tag, " init done high"}, 32'(init_done_o), 32'd1);
   endtask
`endif

   initial begin
      #12;
      checkOutput("rst s_req", 32'(s_req_o), 32'd0);
      checkOutput("rst s_add", s_add_o, 32'd0);
      checkOutput("rst gnt", 32'(m_gnt_o), 32'd0);
      checkOutput("rst rvalid", 32'(m_r_valid_o), 32'd0);
      checkOutput("rst done", 32'(init_done_o), DONE_RST);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      #2;
`ifdef L2_PRI_BANK_ARB_INIT_EN
      runInitSweep("t1");
`else
      checkOutput("t1 done", 32'(init_done_o), 32'd1);
`endif

      // Single read by m0.
      applyStimulus(2'b01, 2'b11, 32'h1C00_0010, 32'h0, 32'h0, 1'b0);
      slave_rdata = 32'hDEAD_BEEF;
      checkOutput("t2 gnt", 32'(m_gnt_o), 32'h1);
      checkOutput("t2 s_add", s_add_o, 32'h1C00_0010);
      checkOutput("t2 s_wen", 32'(s_wen_o), 32'd1);
      applyStimulus(2'b00, 2'b11, 32'h0, 32'h0, 32'h0, 1'b0);
      checkOutput("t2 rvalid", 32'(m_r_valid_o), 32'h1);
      checkOutput("t2 rdata", m_r_rdata_o, 32'hDEAD_BEEF);
      checkOutput("t2 gnt idle", 32'(m_gnt_o), 32'h0);

      // m1 write brings the pointer back to m0.
      applyStimulus(2'b10, 2'b01, 32'h0, 32'h1C00_0020, 32'h1234_5678, 1'b0);
      checkOutput("t2w gnt", 32'(m_gnt_o), 32'h2);
      checkOutput("t2w s_add", s_add_o, 32'h1C00_0020);
      checkOutput("t2w s_wen", 32'(s_wen_o), 32'd0);
      checkOutput("t2w s_be", 32'(s_be_o), 32'hF);
      checkOutput("t2w s_wdata", s_wdata_o, 32'h1234_5678);

      // Both masters requesting continuously.
      for (int c = 0; c < 6; c++) begin
         applyStimulus(2'b11, 2'b11, 32'h1C00_0100, 32'h1C00_0104, 32'h0, 1'b0);
         slave_rdata = 32'hA000_0000 + 32'(c);
         checkOutput("t3 gnt", 32'(m_gnt_o), (c % 2 == 0) ? 32'h1 : 32'h2);
         checkOutput("t3 s_add", s_add_o, (c % 2 == 0) ? 32'h1C00_0100 : 32'h1C00_0104);
         checkOutput("t3 rvalid", 32'(m_r_valid_o), (c == 0 || c % 2 == 0) ? 32'h2 : 32'h1);
         if (c > 0) begin
            checkOutput("t3 rdata", m_r_rdata_o, 32'hA000_0000 + 32'(c - 1));
         end
      end
      applyStimulus(2'b00, 2'b11, 32'h0, 32'h0, 32'h0, 1'b0);
      checkOutput("t3 last rvalid", 32'(m_r_valid_o), 32'h2);
      checkOutput("t3 last rdata", m_r_rdata_o, 32'hA000_0005);

      // Stalled slave: m1 stays the winner even when m0 joins.
      gnt_low = 1'b1;
      applyStimulus(2'b10, 2'b11, 32'h1C00_0200, 32'h1C00_0030, 32'h0, 1'b0);
      checkOutput("t4 s_req", 32'(s_req_o), 32'd1);
      checkOutput("t4 gnt c1", 32'(m_gnt_o), 32'h0);
      checkOutput("t4 s_add c1", s_add_o, 32'h1C00_0030);
      checkOutput("t4 rvalid c1", 32'(m_r_valid_o), 32'h0);
      applyStimulus(2'b11, 2'b11, 32'h1C00_0200, 32'h1C00_0030, 32'h0, 1'b0);
      checkOutput("t4 gnt c2", 32'(m_gnt_o), 32'h0);
      checkOutput("t4 s_add c2", s_add_o, 32'h1C00_0030);
      applyStimulus(2'b11, 2'b11, 32'h1C00_0200, 32'h1C00_0030, 32'h0, 1'b0);
      checkOutput("t4 gnt c3", 32'(m_gnt_o), 32'h0);
      checkOutput("t4 s_add c3", s_add_o, 32'h1C00_0030);
      applyStimulus(2'b11, 2'b11, 32'h1C00_0200, 32'h1C00_0030, 32'h0, 1'b0);
      gnt_low = 1'b0;
      #1;
      checkOutput("t4 gnt c4", 32'(m_gnt_o), 32'h2);
      checkOutput("t4 s_add c4", s_add_o, 32'h1C00_0030);
      applyStimulus(2'b11, 2'b11, 32'h1C00_0200, 32'h1C00_0030, 32'h0, 1'b0);
      checkOutput("t4 gnt c5", 32'(m_gnt_o), 32'h1);
      checkOutput("t4 s_add c5", s_add_o, 32'h1C00_0200);
      checkOutput("t4 rvalid c5", 32'(m_r_valid_o), 32'h2);
      applyStimulus(2'b00, 2'b11, 32'h0, 32'h0, 32'h0, 1'b0);
      checkOutput("t4 rvalid c6", 32'(m_r_valid_o), 32'h1);

      // Re-init request while m0 is being granted.
      applyStimulus(2'b01, 2'b11, 32'h1C00_0004, 32'h1C00_0008, 32'h55AA_55AA, 1'b1);
      slave_rdata = 32'hCAFE_F00D;
      checkOutput("t5 gnt", 32'(m_gnt_o), 32'h1);
      checkOutput("t5 done before", 32'(init_done_o), 32'd1);
      applyStimulus(2'b10, 2'b01, 32'h1C00_0004, 32'h1C00_0008, 32'h55AA_55AA, 1'b0);
      checkOutput("t5 rvalid", 32'(m_r_valid_o), 32'h1);
      checkOutput("t5 rdata", m_r_rdata_o, 32'hCAFE_F00D);
`ifdef L2_PRI_BANK_ARB_INIT_EN
      runInitSweep("t5");
`else
      checkOutput("t5 done kept", 32'(init_done_o), 32'd1);
`endif
      checkOutput("t5 m1 gnt", 32'(m_gnt_o), 32'h2);
      checkOutput("t5 m1 s_add", s_add_o, 32'h1C00_0008);
      checkOutput("t5 m1 s_wdata", s_wdata_o, 32'h55AA_55AA);
      applyStimulus(2'b00, 2'b11, 32'h0, 32'h0, 32'h0, 1'b0);
      checkOutput("t5 m1 rvalid", 32'(m_r_valid_o), 32'h2);

      // Reset while a response is in flight.
      applyStimulus(2'b01, 2'b11, 32'h1C00_0300, 32'h0, 32'h0, 1'b0);
      checkOutput("t6 gnt", 32'(m_gnt_o), 32'h1);
      applyStimulus(2'b00, 2'b11, 32'h0, 32'h0, 32'h0, 1'b0);
      checkOutput("t6 rvalid before", 32'(m_r_valid_o), 32'h1);
      #1;
      rst_ni  = 1'b0;
      m_req_i = 2'b11;
      #1;
      checkOutput("t6 rvalid in rst", 32'(m_r_valid_o), 32'h0);
      checkOutput("t6 gnt in rst", 32'(m_gnt_o), 32'h0);
      checkOutput("t6 s_req in rst", 32'(s_req_o), 32'd0);
      checkOutput("t6 done in rst", 32'(init_done_o), DONE_RST);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      #2;
`ifdef L2_PRI_BANK_ARB_INIT_EN
      runInitSweep("t6");
`endif
      checkOutput("t6 ptr reset", 32'(m_gnt_o), 32'h1);
      applyStimulus(2'b00, 2'b11, 32'h0, 32'h0, 32'h0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
